cpu_ctrl: RTL and testbench
===========================

# cpu_ctrl

Multi-cycle control unit for the 16-bit CPU core. It owns the program counter and instruction register, and sequences each 24-bit instruction through fetch, decode, execute, memory and writeback. It drives the register-file, ALU and data-memory control lines of the datapath, and handshakes with a data memory that may insert wait states.

## Interface
- `PC_W`, 4: program counter / `iaddr` width (16-instruction ROM).
- `DADDR_W`, 16: data address width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  start pulse; sampled only in IDLE.
- `instr`  in  24  instruction word from ROM at `iaddr`; combinational, valid in FETCH.
- `zero`  in  1  datapath flag: register read port A equals 0.
- `mem_ack`  in  1  data memory completion; sampled only in MEM.
- `iaddr`  out  PC_W  current PC.
- `rf_raddr_a`, `rf_raddr_b`  out  4  register read addresses.
- `rf_waddr`  out  4  register write address.
- `rf_we`  out  1  register write enable.
- `alu_op`  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- `wb_sel`  out  2  00 ALU, 01 imm, 10 data_in.
- `imm`  out  8  IR[7:0].
- `daddr`  out  DADDR_W  {8'h00, IR[7:0]}.
- `mem_req`  out  1  data memory request.
- `data_wr`  out  1  write qualifier for `mem_req`; datapath drives `data_out` from read port A.
- `halted`  out  1  level, core stopped.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.

## Operation
- IR fields: opcode [23:20], DST [19:16], Ra [11:8], Rb [3:0], imm [7:0].
- Opcodes:
  - 0 NOP.
  - 1–4 ADD/SUB/AND/OR: DST <= Ra op Rb.
  - 5 LDI: DST <= imm.
  - 6 LD: DST <= mem[imm].
  - 7 ST: mem[imm] <= R[DST].
  - 8 JMP: PC <= imm[3:0].
  - 9 BEQZ: if R[DST]==0, PC <= imm[3:0].
  - F HALT.
  - A–E are illegal: `illegal` pulses and the instruction executes as NOP.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Transitions:
  - IDLE → FETCH on `run`.
  - FETCH → DECODE; IR <= `instr` at the end of FETCH.
  - DECODE → EXEC for ALU, LDI, NOP, JMP, BEQZ and illegal opcodes.
  - DECODE → MEM for LD and ST.
  - DECODE → HALT for HALT.
  - EXEC → WB for ALU and LDI.
  - EXEC → FETCH for all other opcodes.
  - MEM → WB (LD) or FETCH (ST) in the cycle after `mem_ack`=1; otherwise MEM holds.
  - WB → FETCH.
  - HALT holds until `rst`.
- PC update:
  - PC <= PC+1 on every transition into FETCH, except a taken JMP or BEQZ, which loads imm[3:0].
  - PC wraps 15 → 0.
- `rf_raddr_a` = DST for ST and BEQZ, Ra otherwise; `rf_raddr_b` = Rb. Both are valid from DECODE through the end of the instruction.
- `alu_op` = opcode-1 for opcodes 1–4, 00 otherwise.
- `rf_we` is high only in WB, with `rf_waddr`=DST. `wb_sel` is 00 for ALU, 01 for LDI, 10 for LD.
- `mem_req` is high for every MEM cycle. `data_wr` is high in MEM for ST only.
- `zero` is sampled in EXEC for BEQZ.
- `run` outside IDLE is ignored. `mem_ack` outside MEM is ignored.

## Timing
- Reset state: IDLE, PC=0, IR=0. All outputs are 0 from the cycle after the `rst` edge, including `iaddr`, `mem_req`, `halted` and `illegal`.
- All outputs are decoded from registered state and IR; there is no combinational path from any input to any output.
- Latency per instruction:
  - ALU/LDI: 4 cycles (FETCH, DECODE, EXEC, WB).
  - NOP, JMP, BEQZ, illegal: 3 cycles.
  - LD: 3 + n cycles, with n ≥ 1 MEM cycles. `mem_ack` in the first MEM cycle gives n=1.
  - ST: 2 + n cycles.
- `illegal` is high only in the DECODE cycle of an opcode A–E.
- `halted` rises in the cycle after DECODE of HALT.
- `rst` during MEM: `mem_req` and `data_wr` are low the next cycle. No writeback occurs and PC=0.
- `rst` and `run` in the same cycle: `rst` wins; the block is in IDLE next cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams;
  - the state enum;
  - `alu_op` and `wb_sel` encodings;
  - IR field slice constants.
- One combinational sub-module, `cpu_decode`: IR → class (alu/imm/ld/st/jmp/bz/halt/illegal), `alu_op`, `wb_sel`, read-address selection.
- FSM, PC and IR registers live in `cpu_ctrl`.

## Test plan
- Reset, `run`, ROM[0]=0x510005 (LDI R1,5): `rf_we`=1 in cycle 4 with `rf_waddr`=1, `wb_sel`=01, `imm`=0x05; `iaddr`=1 in the next FETCH.
- ROM[1]=0x130102 (ADD R3,R1,R2): `rf_raddr_a`=1, `rf_raddr_b`=2 from DECODE; in WB `alu_op`=00, `rf_waddr`=3.
- LD R4,[0x20] (0x640020), `mem_ack` raised on the 3rd MEM cycle: `mem_req` high exactly 3 cycles, `daddr`=0x0020, `data_wr`=0, then WB with `wb_sel`=10. Repeat with ST (0x740020): `data_wr`=1, `rf_raddr_a`=4, no WB.
- BEQZ (0x92000C):
  - `zero`=1 → next `iaddr`=0xC.
  - `zero`=0 → `iaddr`=PC+1.
  - NOP at PC=15 → `iaddr`=0.
- Opcode 0xA: `illegal` pulses one cycle and PC advances. HALT (0xF00000): `halted`=1 and stays; `run` pulses are ignored.
- `rst` asserted mid-MEM with `mem_ack`=0: `mem_req`=0 and `iaddr`=0 next cycle, state IDLE, no `rf_we`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path: opcodes, IR field
// positions, FSM states, instruction classes and datapath control encodings.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int IR_OP_HI  = 23;
  localparam int IR_OP_LO  = 20;
  localparam int IR_DST_HI = 19;
  localparam int IR_DST_LO = 16;
  localparam int IR_RA_HI  = 11;
  localparam int IR_RA_LO  = 8;
  localparam int IR_RB_HI  = 3;
  localparam int IR_RB_LO  = 0;
  localparam int IR_IMM_HI = 7;
  localparam int IR_IMM_LO = 0;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_IMM = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP  = 4'd0,
    CLS_ALU  = 4'd1,
    CLS_IMM  = 4'd2,
    CLS_LD   = 4'd3,
    CLS_ST   = 4'd4,
    CLS_JMP  = 4'd5,
    CLS_BZ   = 4'd6,
    CLS_HALT = 4'd7,
    CLS_ILL  = 4'd8
  } cls_e;

endpackage

// File: rtl/cpu_decode.sv
// Purely combinational instruction decoder: classifies the IR and derives the
// ALU operation, writeback source and register read addresses.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [23:0] ir_i,
  output cls_e        cls_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  wb_sel_o,
  output logic [3:0]  raddr_a_o,
  output logic [3:0]  raddr_b_o
);

  logic [3:0] op;
  logic [3:0] dst;
  logic [3:0] ra;
  logic       unused_ir_bits;

  assign op  = ir_i[IR_OP_HI:IR_OP_LO];
  assign dst = ir_i[IR_DST_HI:IR_DST_LO];
  assign ra  = ir_i[IR_RA_HI:IR_RA_LO];
  assign unused_ir_bits = ^ir_i[15:12];

  always_comb begin
    cls_o    = CLS_ILL;
    alu_op_o = ALU_ADD;
    wb_sel_o = WB_ALU;
    case (op)
      OP_NOP: cls_o = CLS_NOP;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        cls_o    = CLS_ALU;
        // opcodes 1..4 map onto ADD..OR by subtracting one (4 wraps to 11)
        alu_op_o = op[1:0] - 2'd1;
      end
      OP_LDI: begin
        cls_o    = CLS_IMM;
        wb_sel_o = WB_IMM;
      end
      OP_LD: begin
        cls_o    = CLS_LD;
        wb_sel_o = WB_MEM;
      end
      OP_ST:   cls_o = CLS_ST;
      OP_JMP:  cls_o = CLS_JMP;
      OP_BEQZ: cls_o = CLS_BZ;
      OP_HALT: cls_o = CLS_HALT;
      default: cls_o = CLS_ILL;
    endcase
  end

  // ST and BEQZ read their DST register on port A (store data / zero test)
  assign raddr_a_o = (op == OP_ST || op == OP_BEQZ) ? dst : ra;
  assign raddr_b_o = ir_i[IR_RB_HI:IR_RB_LO];

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit: owns PC and IR and steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB; every output is decoded from registered state.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int DADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [23:0]        instr,
  input  logic               zero,
  input  logic               mem_ack,
  output logic [PC_W-1:0]    iaddr,
  output logic [3:0]         rf_raddr_a,
  output logic [3:0]         rf_raddr_b,
  output logic [3:0]         rf_waddr,
  output logic               rf_we,
  output logic [1:0]         alu_op,
  output logic [1:0]         wb_sel,
  output logic [7:0]         imm,
  output logic [DADDR_W-1:0] daddr,
  output logic               mem_req,
  output logic               data_wr,
  output logic               halted,
  output logic               illegal,
  output logic [2:0]         dbg_state
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [23:0]     ir_q, ir_d;

  cls_e            cls;
  logic [1:0]      dec_alu_op;
  logic [1:0]      dec_wb_sel;
  logic [3:0]      dec_raddr_a;
  logic [3:0]      dec_raddr_b;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_tgt;
  logic            br_taken;

  cpu_decode u_decode (
    .ir_i      (ir_q),
    .cls_o     (cls),
    .alu_op_o  (dec_alu_op),
    .wb_sel_o  (dec_wb_sel),
    .raddr_a_o (dec_raddr_a),
    .raddr_b_o (dec_raddr_b)
  );

  assign pc_inc   = pc_q + PC_W'(1);
  assign pc_tgt   = PC_W'(ir_q[3:0]);
  assign br_taken = (cls == CLS_JMP) || (cls == CLS_BZ && zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Memory handshake: mem_req stays high for every MEM cycle; the access
  // completes on the first rising edge where mem_ack is sampled high in MEM,
  // and mem_ack is ignored in every other state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = instr;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (cls)
          CLS_LD, CLS_ST: state_d = ST_MEM;
          CLS_HALT:       state_d = ST_HALT;
          default:        state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        if (cls == CLS_ALU || cls == CLS_IMM) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
          pc_d    = br_taken ? pc_tgt : pc_inc;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (cls == CLS_LD) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
          end
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign iaddr      = pc_q;
  assign rf_raddr_a = dec_raddr_a;
  assign rf_raddr_b = dec_raddr_b;
  assign rf_waddr   = ir_q[IR_DST_HI:IR_DST_LO];
  assign rf_we      = (state_q == ST_WB);
  assign alu_op     = dec_alu_op;
  assign wb_sel     = dec_wb_sel;
  assign imm        = ir_q[IR_IMM_HI:IR_IMM_LO];
  assign daddr      = {{(DADDR_W-8){1'b0}}, ir_q[IR_IMM_HI:IR_IMM_LO]};
  assign mem_req    = (state_q == ST_MEM);
  assign data_wr    = (state_q == ST_MEM) && (cls == CLS_ST);
  assign halted     = (state_q == ST_HALT);
  assign illegal    = (state_q == ST_DECODE) && (cls == CLS_ILL);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: an instruction-level model walks the ROM program and
// predicts per-cycle control outputs; writebacks go through an expected queue.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, zero, mem_ack;
  logic [23:0] instr;
  logic [3:0]  iaddr, rf_raddr_a, rf_raddr_b, rf_waddr;
  logic        rf_we, mem_req, data_wr, halted, illegal;
  logic [1:0]  alu_op, wb_sel;
  logic [7:0]  imm;
  logic [15:0] daddr;
  logic [2:0]  dbg_state;

  logic [23:0] rom [16];
  logic [7:0]  exp_q[$];
  logic [3:0]  m_pc;
  int          n_chk = 0;
  int          n_bad = 0;

  // clock / reset block
  always #5 clk = ~clk;

  assign instr = rom[iaddr];

  cpu_ctrl #(.PC_W(4), .DADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .instr      (instr),
    .zero       (zero),
    .mem_ack    (mem_ack),
    .iaddr      (iaddr),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_waddr   (rf_waddr),
    .rf_we      (rf_we),
    .alu_op     (alu_op),
    .wb_sel     (wb_sel),
    .imm        (imm),
    .daddr      (daddr),
    .mem_req    (mem_req),
    .data_wr    (data_wr),
    .halted     (halted),
    .illegal    (illegal),
    .dbg_state  (dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {15'd0, iaddr, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, alu_op, wb_sel,
            imm, daddr, mem_req, data_wr, halted, illegal};
  endfunction

  // scoreboard: every register write must match the oldest expected record
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) chk("wb_spurious", rf_we, 1'b0);
      else chk("wb_rec", {rf_waddr, wb_sel, alu_op}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    run     = 1'($urandom_range(0, 1));
    mem_ack = 1'($urandom_range(0, 1));
    zero    = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; zero = 1'b0;
    tick();
    tick();
    rst  = 1'b0;
    m_pc = 4'd0;
  endtask

  task automatic start();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // Executes rom[m_pc] from its FETCH cycle; ack_n=0 picks a random wait,
  // zv<0 picks a random zero flag for the EXEC cycle.
  task automatic exec_one(input int ack_n, input int zv, output bit stop);
    logic [23:0] ir;
    logic [3:0]  op, dst, ra, rb;
    logic [7:0]  im;
    logic [1:0]  e_sel, e_alu;
    logic        z;
    int          n;
    stop = 1'b0;
    ir = rom[m_pc];
    op = ir[23:20]; dst = ir[19:16]; ra = ir[11:8]; rb = ir[3:0]; im = ir[7:0];
    e_sel = (op == 4'h5) ? 2'd1 : (op == 4'h6) ? 2'd2 : 2'd0;
    e_alu = (op >= 4'h1 && op <= 4'h4) ? 2'(op - 4'h1) : 2'd0;
    z = 1'b0;

    chk("f_iaddr", iaddr, m_pc);
    chk("f_quiet", {mem_req, rf_we, illegal, halted}, 4'b0);
    noise(); tick();

    chk("d_illegal", illegal, (op >= 4'hA && op <= 4'hE));
    chk("d_ra", rf_raddr_a, (op == 4'h7 || op == 4'h9) ? dst : ra);
    chk("d_rb", rf_raddr_b, rb);
    chk("d_imm", imm, im);
    chk("d_quiet", {mem_req, rf_we, halted}, 3'b0);
    noise(); tick();

    if (op == 4'hF) begin
      for (int i = 0; i < 5; i++) begin
        chk("h_halted", halted, 1'b1);
        chk("h_iaddr", iaddr, m_pc);
        chk("h_quiet", {mem_req, rf_we, illegal}, 3'b0);
        noise();
        run = 1'(i % 2 == 0);
        tick();
      end
      stop = 1'b1;
      return;
    end

    if (op == 4'h6 || op == 4'h7) begin
      n = (ack_n > 0) ? ack_n : int'($urandom_range(1, 4));
      for (int k = 1; k <= n; k++) begin
        chk("m_req", mem_req, 1'b1);
        chk("m_wr", data_wr, op == 4'h7);
        chk("m_daddr", daddr, {8'h00, im});
        chk("m_ra", rf_raddr_a, (op == 4'h7) ? dst : ra);
        chk("m_we", rf_we, 1'b0);
        noise();
        mem_ack = (k == n);
        if (k == n && op == 4'h6) exp_q.push_back({dst, e_sel, e_alu});
        tick();
      end
    end else begin
      chk("e_quiet", {mem_req, rf_we, illegal}, 3'b0);
      noise();
      z = (zv >= 0) ? zv[0] : 1'($urandom_range(0, 1));
      zero = z;
      if (op >= 4'h1 && op <= 4'h5) exp_q.push_back({dst, e_sel, e_alu});
      tick();
    end

    if (op >= 4'h1 && op <= 4'h6) begin
      chk("w_we", rf_we, 1'b1);
      chk("w_waddr", rf_waddr, dst);
      chk("w_sel", wb_sel, e_sel);
      chk("w_alu", alu_op, e_alu);
      chk("w_rb", rf_raddr_b, rb);
      chk("w_req", mem_req, 1'b0);
      noise(); tick();
    end

    if (op == 4'h8 || (op == 4'h9 && z)) m_pc = im[3:0];
    else m_pc = m_pc + 4'd1;
  endtask

  initial begin
    bit stop;
    rst = 1'b1; run = 1'b0; zero = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 24'h0;

    // reset state
    do_reset();
    chk("rst_outs", all_outs(), 64'd0);

    // directed program
    rom[0]  = 24'h510005; rom[1]  = 24'h130102; rom[2]  = 24'h640020;
    rom[3]  = 24'h740020; rom[4]  = 24'h92000C; rom[12] = 24'hA00000;
    rom[13] = 24'h92000C; rom[14] = 24'h80000F; rom[15] = 24'h000000;
    start();
    exec_one(0, -1, stop);
    exec_one(0, -1, stop);
    exec_one(3, -1, stop);
    exec_one(3, -1, stop);
    exec_one(0, 1, stop);
    exec_one(0, -1, stop);
    exec_one(0, 0, stop);
    exec_one(0, -1, stop);
    exec_one(0, -1, stop);
    exec_one(0, -1, stop);
    chk("dir_pc", iaddr, 4'd1);

    // HALT and ignored run pulses
    rom[0] = 24'hF00000;
    do_reset();
    start();
    exec_one(0, -1, stop);
    chk("halt_stop", stop, 1'b1);

    // reset in the middle of a memory wait
    rom[0] = 24'h640020;
    do_reset();
    start();
    tick();
    tick();
    chk("mr_req1", mem_req, 1'b1);
    mem_ack = 1'b0;
    tick();
    chk("mr_req2", mem_req, 1'b1);
    rst = 1'b1;
    tick();
    chk("mr_outs", all_outs(), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_idle", {mem_req, rf_we, iaddr}, 6'd0);
    end

    // rst and run together: reset wins, block stays idle
    rst = 1'b1; run = 1'b1;
    tick();
    chk("rr_outs", all_outs(), 64'd0);
    rst = 1'b0; run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_idle", {mem_req, rf_we}, 2'd0);
    end

    // random programs
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 16; i++) begin
        logic [3:0] op;
        op = ($urandom_range(0, 99) < 4) ? 4'hF : 4'($urandom_range(0, 14));
        rom[i] = {op, 20'($urandom)};
      end
      do_reset();
      chk("rnd_rst", all_outs(), 64'd0);
      start();
      stop = 1'b0;
      for (int k = 0; k < 40 && !stop; k++) exec_one(0, -1, stop);
    end

    chk("q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
